// File: rtl/pipelined_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pipelined_adder                                            |
// | Description : Pipelined ripple-carry adder with carry-in, carry-out and  |
// |               signed-overflow flag. Each of STAGES stages adds one       |
// |               WIDTH/STAGES-bit slice; a valid/ready handshake on both    |
// |               sides provides back-pressure with collapsing bubbles.      |
// | Parameters  : WIDTH  - operand/sum width (>= 2)                          |
// |               STAGES - pipeline depth / slice count (WIDTH % STAGES == 0)|
// | Ports       : clk, rst_n (async, active low)                             |
// |               in_valid/in_ready, in_a, in_b, in_cin  - operand beat      |
// |               out_valid/out_ready, out_sum, out_cout, out_ovf - result   |
// |               sat_mode (only with PIPELINED_ADDER_SATURATE_EN)           |
// | Options     : `define PIPELINED_ADDER_SATURATE_EN adds sat_mode; on      |
// |               signed overflow the sum clamps to the signed max/min.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
`ifdef PIPELINED_ADDER_SATURATE_EN
    input  logic             sat_mode,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int SLICE_W = WIDTH / STAGES;

    if ((STAGES < 1) || (WIDTH < 2) || ((WIDTH % STAGES) != 0)) begin : g_param_check
        $error("pipelined_adder: WIDTH must be >= 2 and an exact multiple of STAGES");
    end

    // ------------------------------------------------------------------
    // Handshake: a stage advances when its successor is empty or is itself
    // advancing, so bubbles collapse and the chain reacts to out_ready in
    // the same cycle.
    // ------------------------------------------------------------------
    logic [STAGES-1:0] r_vld;
    logic [STAGES-1:0] w_adv;
    logic [STAGES-1:0] w_load;

    always_comb begin
        w_adv           = '0;
        w_adv[STAGES-1] = r_vld[STAGES-1] & out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            w_adv[k] = r_vld[k] & (~r_vld[k+1] | w_adv[k+1]);
        end
    end

    assign in_ready  = ~r_vld[0] | w_adv[0];
    assign out_valid = r_vld[STAGES-1];

    always_comb begin
        w_load    = '0;
        w_load[0] = in_valid & in_ready;
        for (int k = 1; k < STAGES; k++) begin
            w_load[k] = w_adv[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
        end else begin
            r_vld <= w_load | (r_vld & ~w_adv);
        end
    end

    // ------------------------------------------------------------------
    // Datapath. r_x of stage k holds the finished sum bits [HI-1:0] in its
    // low part and the still-unused A bits above them, so one word carries
    // both the de-skewed result and the skewed operand. r_y holds the
    // remaining B bits, LSB-aligned to the next slice.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * SLICE_W;
        localparam int HI = LO + SLICE_W;

        logic [WIDTH-1:0]    w_x_in;
        logic [WIDTH-LO-1:0] w_y_in;
        logic                w_c_in;
        logic [SLICE_W:0]    w_add;
        logic [WIDTH-1:0]    w_x_nxt;
        logic [WIDTH-1:0]    w_x_d;
        logic [WIDTH-1:0]    r_x;
        logic                r_c;
`ifdef PIPELINED_ADDER_SATURATE_EN
        logic                w_s_in;
`endif

        if (k == 0) begin : g_head
            assign w_x_in = in_a;
            assign w_y_in = in_b;
            assign w_c_in = in_cin;
`ifdef PIPELINED_ADDER_SATURATE_EN
            assign w_s_in = sat_mode;
`endif
        end else begin : g_link
            assign w_x_in = g_stage[k-1].r_x;
            assign w_y_in = g_stage[k-1].g_fwd.r_y;
            assign w_c_in = g_stage[k-1].r_c;
`ifdef PIPELINED_ADDER_SATURATE_EN
            assign w_s_in = g_stage[k-1].g_fwd.r_s;
`endif
        end

        assign w_add = {1'b0, w_x_in[HI-1:LO]} + {1'b0, w_y_in[SLICE_W-1:0]}
                     + {{SLICE_W{1'b0}}, w_c_in};

        always_comb begin
            w_x_nxt          = w_x_in;
            w_x_nxt[HI-1:LO] = w_add[SLICE_W-1:0];
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [WIDTH-HI-1:0] r_y;
`ifdef PIPELINED_ADDER_SATURATE_EN
            logic                r_s;
`endif
            assign w_x_d = w_x_nxt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_y <= '0;
`ifdef PIPELINED_ADDER_SATURATE_EN
                    r_s <= 1'b0;
`endif
                end else if (w_load[k]) begin
                    r_y <= w_y_in[WIDTH-LO-1:SLICE_W];
`ifdef PIPELINED_ADDER_SATURATE_EN
                    r_s <= w_s_in;
`endif
                end
            end
        end else begin : g_tail
            logic w_msb_cin;
            logic w_ovf;
            logic r_ovf;

            // Carry into the MSB recovered from the MSB sum bit and operands.
            assign w_msb_cin = w_add[SLICE_W-1] ^ w_x_in[WIDTH-1] ^ w_y_in[SLICE_W-1];
            assign w_ovf     = w_msb_cin ^ w_add[SLICE_W];

`ifdef PIPELINED_ADDER_SATURATE_EN
            // Overflow implies equal operand signs, so A's MSB picks the clamp.
            assign w_x_d = (w_s_in && w_ovf)
                         ? (w_x_in[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                            : {1'b0, {(WIDTH-1){1'b1}}})
                         : w_x_nxt;
`else
            assign w_x_d = w_x_nxt;
`endif

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ovf <= 1'b0;
                end else if (w_load[k]) begin
                    r_ovf <= w_ovf;
                end
            end

            assign out_sum  = r_x;
            assign out_cout = r_c;
            assign out_ovf  = r_ovf;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_x <= '0;
                r_c <= 1'b0;
            end else if (w_load[k]) begin
                r_x <= w_x_d;
                r_c <= w_add[SLICE_W];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_pipelined_adder                                         |
// | Description : Self-checking bench for pipelined_adder: a 16-bit/4-stage |
// |               instance and a 4-bit/2-stage instance, both compared      |
// |               against an arithmetic reference model via a scoreboard.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_pipelined_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        in_cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_sum;
    logic        out_cout;
    logic        out_ovf;
    logic        sat1 = 1'b0;

    logic        v2 = 1'b0;
    logic        rdy2;
    logic [3:0]  a2 = '0;
    logic [3:0]  b2 = '0;
    logic        c2 = 1'b0;
    logic        ov2;
    logic        or2 = 1'b0;
    logic [3:0]  s2;
    logic        co2;
    logic        of2;
    logic        sat2 = 1'b0;

    pipelined_adder #(.WIDTH(16), .STAGES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
`ifdef PIPELINED_ADDER_SATURATE_EN
        .sat_mode  (sat1),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    pipelined_adder #(.WIDTH(4), .STAGES(2)) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v2),
        .in_ready  (rdy2),
        .in_a      (a2),
        .in_b      (b2),
        .in_cin    (c2),
`ifdef PIPELINED_ADDER_SATURATE_EN
        .sat_mode  (sat2),
`endif
        .out_valid (ov2),
        .out_ready (or2),
        .out_sum   (s2),
        .out_cout  (co2),
        .out_ovf   (of2)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int q1[$];
    int q2[$];
    int n_out1 = 0;
    int n_out2 = 0;
    int last1 = 0;
    int hold1 = 0;
    logic stall1 = 1'b0;
    logic s_ov1 = 1'b0;
    logic s_acc1 = 1'b0;
    logic s_acc2 = 1'b0;
    int n, sent, ir_low, base, idx;

    // Reference: plain integer addition, result packed as {ovf, cout, sum}.
    function automatic int model(int w, int a, int b, int cin, int sat);
        int full, sum, cout, sa, sb, ss, ovf;
        full = a + b + cin;
        sum  = full & ((1 << w) - 1);
        cout = (full >> w) & 1;
        sa   = (a >> (w - 1)) & 1;
        sb   = (b >> (w - 1)) & 1;
        ss   = (sum >> (w - 1)) & 1;
        ovf  = (sa == sb && ss != sa) ? 1 : 0;
        if (sat != 0 && ovf != 0)
            sum = (sa != 0) ? (1 << (w - 1)) : ((1 << (w - 1)) - 1);
        return (ovf << (w + 1)) | (cout << w) | sum;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: sample both DUTs mid-cycle, update scoreboards,
    // then return just after the rising edge for the next drive.
    task automatic cycle();
        int obs1, obs2;
        @(negedge clk);
        obs1   = {14'd0, out_ovf, out_cout, out_sum};
        obs2   = {26'd0, of2, co2, s2};
        s_ov1  = out_valid;
        s_acc1 = rst_n && in_valid && in_ready;
        s_acc2 = rst_n && v2 && rdy2;
        if (stall1) begin
            chk("d1_stall_valid", {31'd0, out_valid}, 1);
            chk("d1_stall_data", obs1, hold1);
        end
        stall1 = out_valid && !out_ready;
        hold1  = obs1;
        if (out_valid && out_ready) begin
            chk("d1_result_pending", {31'd0, q1.size() > 0}, 1);
            if (q1.size() > 0) begin
                chk("d1_result", obs1, q1.pop_front());
                last1 = obs1;
                n_out1++;
            end
        end
        if (s_acc1) q1.push_back(model(16, int'(in_a), int'(in_b), int'(in_cin), int'(sat1)));
        if (ov2 && or2) begin
            chk("d2_result_pending", {31'd0, q2.size() > 0}, 1);
            if (q2.size() > 0) begin
                chk("d2_result", obs2, q2.pop_front());
                n_out2++;
            end
        end
        if (s_acc2) q2.push_back(model(4, int'(a2), int'(b2), int'(c2), int'(sat2)));
        @(posedge clk);
        #1;
    endtask

    task automatic drain1();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 40 && q1.size() > 0; t++) cycle();
        chk("d1_drain_empty", q1.size(), 0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // 1: reset held three cycles
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("t1_out_valid", {31'd0, out_valid}, 0);
        chk("t1_out_sum", {16'd0, out_sum}, 0);
        chk("t1_out_cout", {31'd0, out_cout}, 0);
        chk("t1_out_ovf", {31'd0, out_ovf}, 0);
        chk("t1_in_ready", {31'd0, in_ready}, 1);
        chk("t1_d2_in_ready", {31'd0, rdy2}, 1);
        chk("t1_d2_out_valid", {31'd0, ov2}, 0);
        @(posedge clk);
        #1;

        // 2: latency and carry/overflow corners
        in_valid = 1'b1; in_a = 16'hFFFF; in_b = 16'h0001; in_cin = 1'b0; out_ready = 1'b1;
        cycle();
        chk("t2_accept", {31'd0, s_acc1}, 1);
        in_valid = 1'b0;
        for (n = 1; n <= 10; n++) begin
            cycle();
            if (s_ov1) break;
        end
        chk("t2_latency", n, 4);
        chk("t2_wrap_result", last1, 32'h0001_0000);
        in_valid = 1'b1; in_a = 16'h7FFF; in_b = 16'h0001; in_cin = 1'b0;
        cycle();
        drain1();
        chk("t2_ovf_result", last1, 32'h0002_8000);

        // 3: eight back-to-back beats
        base = n_out1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_a = 16'(i * 16'h1111);
            in_b = 16'h0F0F;
            in_cin = 1'(i & 1);
            cycle();
            chk("t3_accept", {31'd0, s_acc1}, 1);
        end
        drain1();
        chk("t3_count", n_out1 - base, 8);

        // 4: back-pressure, 6 stalled cycles while streaming 10 beats
        base = n_out1; sent = 0; ir_low = -1; out_ready = 1'b0;
        in_a = 16'($urandom); in_b = 16'($urandom); in_cin = 1'($urandom_range(0, 1));
        for (int t = 0; t < 80 && sent < 10; t++) begin
            in_valid = 1'b1;
            if (t == 6) out_ready = 1'b1;
            cycle();
            if (s_acc1) begin
                sent++;
                in_a = 16'($urandom); in_b = 16'($urandom); in_cin = 1'($urandom_range(0, 1));
            end else if (ir_low < 0) begin
                ir_low = sent;
            end
        end
        drain1();
        chk("t4_in_ready_drop", ir_low, 4);
        chk("t4_count", n_out1 - base, 10);

        // Random traffic with random back-pressure
        for (int t = 0; t < 120; t++) begin
            in_valid = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_a = 16'($urandom); in_b = 16'($urandom); in_cin = 1'($urandom_range(0, 1));
            cycle();
        end
        drain1();

        // 5: reset with three beats in flight
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_a = 16'($urandom); in_b = 16'($urandom); in_cin = 1'($urandom_range(0, 1));
            cycle();
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_out_valid", {31'd0, out_valid}, 0);
        chk("t5_rst_out_sum", {16'd0, out_sum}, 0);
        chk("t5_rst_out_cout", {31'd0, out_cout}, 0);
        chk("t5_rst_out_ovf", {31'd0, out_ovf}, 0);
        q1.delete();
        stall1 = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("t5_in_ready", {31'd0, in_ready}, 1);
        for (int t = 0; t < 6; t++) begin
            cycle();
            chk("t5_no_stale", {31'd0, s_ov1}, 0);
        end
        in_valid = 1'b1; in_a = 16'h1234; in_b = 16'h4321; in_cin = 1'b0;
        cycle();
        drain1();
        chk("t5_result", last1, 32'h0000_5555);

`ifdef PIPELINED_ADDER_SATURATE_EN
        // Saturation: positive and negative clamps
        sat1 = 1'b1;
        in_valid = 1'b1; in_a = 16'h7FFF; in_b = 16'h0001; in_cin = 1'b0;
        cycle();
        drain1();
        chk("sat_pos", last1, 32'h0002_7FFF);
        in_valid = 1'b1; in_a = 16'h8000; in_b = 16'h8000; in_cin = 1'b0;
        cycle();
        drain1();
        chk("sat_neg", last1, 32'h0003_8000);
        sat1 = 1'b0;
`endif

        // 6: exhaustive 4-bit/2-stage with random out_ready
        idx = 0;
        for (int t = 0; t < 6000 && idx < 512; t++) begin
            v2  = 1'b1;
            a2  = idx[3:0];
            b2  = idx[7:4];
            c2  = idx[8];
            or2 = 1'($urandom_range(0, 1));
            cycle();
            if (s_acc2) idx++;
        end
        v2 = 1'b0; or2 = 1'b1;
        for (int t = 0; t < 20 && q2.size() > 0; t++) cycle();
        chk("t6_sent", idx, 512);
        chk("t6_count", n_out2, 512);
        chk("t6_drain_empty", q2.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
Parametrised, pipelined ripple-carry adder with carry-in, carry-out and signed-overflow flag. It succeeds the combinational half/full adders for wide datapaths where a single ripple chain misses timing. Each stage adds one WIDTH/STAGES-bit slice. A valid/ready handshake on both sides supports back-pressure. It sits between operand producers and any result consumer in the arithmetic examples.

Parameters:
WIDTH, 16, operand/sum width in bits; must be >= 2.
STAGES, 4, pipeline depth and slice count; WIDTH % STAGES == 0 required, otherwise elaboration error via generate-time check.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept operand beat
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_cin  input  1  carry-in
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_sum  output  WIDTH  in_a + in_b + in_cin, modulo 2^WIDTH
out_cout  output  1  carry out of MSB
out_ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Slice width C = WIDTH/STAGES. Stage k (0..STAGES-1) adds bits [k*C +: C] of A and B plus the carry registered from stage k-1. Stage 0 uses in_cin.
- Operand slices not yet consumed travel with their beat (skew registers). Completed sum slices are carried forward (de-skew) so out_sum is aligned.
- Each stage has a valid bit. Stage k advances when valid and (stage k+1 empty or stage k+1 advancing). The last stage advances when out_ready or !out_valid.
- Accept when in_valid && in_ready. in_ready = !stage0_valid || stage0_advances (combinational from out_ready through the pipeline).
- Latency with no stall: result visible on out_valid exactly STAGES cycles after the accept edge. Throughput is 1 beat/cycle. Results leave in strict input order.
- While out_valid && !out_ready: out_sum, out_cout and out_ovf stay stable. No beat is dropped or duplicated.
- Bubbles collapse. An empty stage is filled even when downstream is stalled. Capacity is STAGES beats.
- out_ovf is computed in the final stage from the MSB carry-in and carry-out. Meaningful for signed interpretation only; it is always driven.
- Reset, at any time including mid-operation: all stage valids, out_valid, out_sum, out_cout and out_ovf clear to 0 immediately and asynchronously. In-flight beats are discarded. in_ready reads 1 from the first cycle after deassertion.
- Datapath registers other than the valids need no reset, but outputs must read 0 while out_valid is 0 after reset.
- STAGES == 1 degenerates to a single registered full-width adder with latency 1.

Optional Feature:
PIPELINED_ADDER_SATURATE_EN:
- Defined: a top-level input sat_mode (1 bit) is added and sampled with the beat. When sat_mode=1 and signed overflow occurs, out_sum clamps to 0x7FF..F (positive overflow) or 0x800..0 (negative overflow). out_ovf still reports the overflow. out_cout is unchanged.
- Not defined: port absent, no saturation logic, wrap-around result only.

Test Plan (WIDTH=16, STAGES=4 unless noted):
1. Reset held 3 cycles, then released -> out_valid=0, out_sum=0x0000, out_cout=0, out_ovf=0, in_ready=1.
2. a=0xFFFF, b=0x0001, cin=0, out_ready=1 -> exactly 4 cycles later out_sum=0x0000, out_cout=1, out_ovf=0. Then a=0x7FFF, b=0x0001 -> out_sum=0x8000, out_cout=0, out_ovf=1.
3. 8 back-to-back beats, a=i*0x1111, b=0x0F0F, cin=i&1, out_ready=1 -> 8 consecutive valid results, in order, each matching the reference model.
4. Stream 10 beats with out_ready=0 for 6 cycles -> in_ready drops after 4 accepted beats; out_sum stable while stalled; after out_ready=1, all 10 results emerge in order with none lost or duplicated.
5. rst_n pulsed low while 3 beats are in flight -> outputs and valids clear immediately, no stale result appears; the next beat a=0x1234, b=0x4321 yields 0x5555.
6. WIDTH=4, STAGES=2, all 512 a/b/cin combinations with random out_ready -> every sum, cout and ovf matches the model. With PIPELINED_ADDER_SATURATE_EN defined, sat_mode=1 and a=0x7FFF, b=0x0001 -> out_sum=0x7FFF, out_ovf=1.
